// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory controller.
// State encoding, grant bit positions, default address width.
package lc3_pkg;

    localparam int ADDR_W_DEF = 7;

    localparam logic [15:0] ABORT_DATA = 16'h0000;

    localparam int GNT_DATA  = 0;
    localparam int GNT_FETCH = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/lc3_mem_arb.sv
// Data-over-fetch arbiter with a starvation guard.
// Grant is combinational; the counter moves when a grant is taken.
module lc3_mem_arb
    import lc3_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       take,
    output logic [1:0] grant
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_d;
    logic          fetch_win;

    // Pick a winner and advance the consecutive-data-grant count
    always_comb begin
        fetch_win = if_req &&
                    (!d_req || starve_q == CW'(STARVE_MAX));
        grant = 2'b00;
        grant[GNT_FETCH] = fetch_win;
        grant[GNT_DATA]  = d_req && !fetch_win;
        starve_d = starve_q;
        if (take) begin
            if (fetch_win) begin
                starve_d = '0;
            end else if (d_req &&
                         starve_q != CW'(STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: arbitrates fetch and data ports
// onto one single-word memory with range and timeout aborts.
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic [15:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [15:0]       d_addr,
    input  logic [15:0]       d_wdata,
    output logic [15:0]       d_rdata,
    output logic              d_ack,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err_range,
    output logic              err_timeout
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [WCW-1:0]     wait_q, wait_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        if_rdata_q, if_rdata_d;
    logic [15:0]        d_rdata_q, d_rdata_d;
    logic               fetch_q, fetch_d;
    logic               we_q, we_d;
    logic               re_q, re_d;
    logic               wr_q, wr_d;
    logic               if_ack_q, if_ack_d;
    logic               d_ack_q, d_ack_d;
    logic               err_range_q, err_range_d;
    logic               err_timeout_q, err_timeout_d;

    logic [1:0]         grant;
    logic               take;
    logic               sel_fetch;
    logic               sel_we;
    logic [15:0]        sel_addr;
    logic               finish;

    lc3_mem_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (if_req),
        .d_req  (d_req),
        .take   (take),
        .grant  (grant)
    );

    // Next-state, latched operands, strobes, acks and error pulses
    always_comb begin
        sel_fetch     = grant[GNT_FETCH];
        sel_addr      = sel_fetch ? if_addr : d_addr;
        sel_we        = !sel_fetch && d_we;
        finish        = 1'b0;
        take          = 1'b0;
        state_d       = state_q;
        wait_d        = wait_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        fetch_d       = fetch_q;
        we_d          = we_q;
        re_d          = re_q;
        wr_d          = wr_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_ack_d      = 1'b0;
        d_ack_d       = 1'b0;
        err_range_d   = 1'b0;
        err_timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    take    = 1'b1;
                    fetch_d = sel_fetch;
                    addr_d  = sel_addr[ADDR_W-1:0];
                    wdata_d = sel_fetch ? 16'h0000 : d_wdata;
                    we_d    = sel_we;
                    wait_d  = '0;
                    if ((sel_addr >> ADDR_W) != 16'h0000) begin
                        state_d     = ST_DONE;
                        err_range_d = 1'b1;
                        if (sel_fetch) begin
                            if_ack_d   = 1'b1;
                            if_rdata_d = ABORT_DATA;
                        end else begin
                            d_ack_d   = 1'b1;
                            d_rdata_d = ABORT_DATA;
                        end
                    end else begin
                        state_d = ST_ISSUE;
                        re_d    = !sel_we;
                        wr_d    = sel_we;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                finish = mem_ready ||
                         wait_q == WCW'(TIMEOUT - 1);
                if (finish) begin
                    state_d       = ST_DONE;
                    re_d          = 1'b0;
                    wr_d          = 1'b0;
                    err_timeout_d = !mem_ready;
                    if (fetch_q) begin
                        if_ack_d = 1'b1;
                        if (!mem_ready) begin
                            if_rdata_d = ABORT_DATA;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_ready) begin
                            d_rdata_d = ABORT_DATA;
                        end else if (!we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset drops any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wait_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            fetch_q       <= 1'b0;
            we_q          <= 1'b0;
            re_q          <= 1'b0;
            wr_q          <= 1'b0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            fetch_q       <= fetch_d;
            we_q          <= we_d;
            re_q          <= re_d;
            wr_q          <= wr_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            if_ack_q      <= if_ack_d;
            d_ack_q       <= d_ack_d;
            err_range_q   <= err_range_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign if_rdata    = if_rdata_q;
    assign if_ack      = if_ack_q;
    assign d_rdata     = d_rdata_q;
    assign d_ack       = d_ack_q;
    assign mem_re      = re_q;
    assign mem_we      = wr_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = state_q != ST_IDLE;
    assign err_range   = err_range_q;
    assign err_timeout = err_timeout_q;

endmodule
